// File: rtl/calc_resp_tracker_if.sv
// Snoop lanes of the calc request/response ports and the tracker's status outputs.
interface calc_resp_tracker_if #(
    parameter int NUM_PORTS = 4,
    parameter int TAG_W     = 2,
    parameter int TIMEOUT   = 64,
    parameter int CNT_W     = 16,
    parameter int LAT_W     = $clog2(TIMEOUT + 1)
);
    logic [NUM_PORTS*4-1:0]         req_cmd_in;
    logic [NUM_PORTS*TAG_W-1:0]     req_tag_in;
    logic [NUM_PORTS*2-1:0]         out_resp;
    logic [NUM_PORTS*TAG_W-1:0]     out_tag;
    logic [NUM_PORTS*(TAG_W+1)-1:0] outstanding;
    logic [NUM_PORTS-1:0]           err_dup;
    logic [NUM_PORTS-1:0]           err_unexp;
    logic [NUM_PORTS-1:0]           err_timeout;
    logic [NUM_PORTS*CNT_W-1:0]     done_cnt;
    logic [NUM_PORTS*LAT_W-1:0]     max_lat;
    logic                           idle;

    modport master (
        output req_cmd_in, req_tag_in, out_resp, out_tag,
        input  outstanding, err_dup, err_unexp, err_timeout, done_cnt, max_lat, idle
    );

    modport slave (
        input  req_cmd_in, req_tag_in, out_resp, out_tag,
        output outstanding, err_dup, err_unexp, err_timeout, done_cnt, max_lat, idle
    );
endinterface

// File: rtl/calc_resp_tracker.sv
// Per-port/per-tag transaction tracker: pending state and age per slot, sticky
// duplicate/unexpected/timeout flags, saturating completion count and worst latency.
module calc_resp_tracker #(
    parameter int NUM_PORTS = 4,
    parameter int TAG_W     = 2,
    parameter int TIMEOUT   = 64,
    parameter int CNT_W     = 16
) (
    input  logic               c_clk,
    input  logic               reset,
    input  logic               clr,
    calc_resp_tracker_if.slave bus
);
    localparam int LAT_W = $clog2(TIMEOUT + 1);
    localparam int SLOTS = 1 << TAG_W;
    localparam int OW    = TAG_W + 1;

    typedef enum logic {S_IDLE, S_PEND} slot_state_e;

    slot_state_e        st_q    [NUM_PORTS][SLOTS];
    slot_state_e        st_d    [NUM_PORTS][SLOTS];
    logic [LAT_W-1:0]   age_q   [NUM_PORTS][SLOTS];
    logic [LAT_W-1:0]   age_d   [NUM_PORTS][SLOTS];
    logic               resp_hit[NUM_PORTS][SLOTS];
    logic               iss_hit [NUM_PORTS][SLOTS];

    logic [OW-1:0]      out_q   [NUM_PORTS];
    logic [OW-1:0]      out_d   [NUM_PORTS];
    logic [CNT_W-1:0]   done_q  [NUM_PORTS];
    logic [CNT_W-1:0]   done_d  [NUM_PORTS];
    logic [LAT_W-1:0]   maxl_q  [NUM_PORTS];
    logic [LAT_W-1:0]   maxl_d  [NUM_PORTS];
    logic [LAT_W-1:0]   lat_ev  [NUM_PORTS];
    logic [NUM_PORTS-1:0] ret_ev, dup_ev, unexp_ev, tmo_ev;
    logic [NUM_PORTS-1:0] dup_q, dup_d, unexp_q, unexp_d, tmo_q, tmo_d;

    always_comb begin
        for (int unsigned p = 0; p < NUM_PORTS; p++) begin
            for (int unsigned t = 0; t < SLOTS; t++) begin
                resp_hit[p][t] = (bus.out_resp[p*2 +: 2] != 2'd0) &&
                                 (bus.out_tag[p*TAG_W +: TAG_W] == TAG_W'(t));
                iss_hit[p][t]  = (bus.req_cmd_in[p*4 +: 4] != 4'd0) &&
                                 (bus.req_tag_in[p*TAG_W +: TAG_W] == TAG_W'(t));
            end
        end
    end

    // Retire, timeout and issue all judge the pre-edge slot state; issue has the last word.
    always_comb begin
        for (int unsigned p = 0; p < NUM_PORTS; p++) begin
            ret_ev[p]   = 1'b0;
            dup_ev[p]   = 1'b0;
            unexp_ev[p] = 1'b0;
            tmo_ev[p]   = 1'b0;
            lat_ev[p]   = '0;
            out_d[p]    = '0;
            for (int unsigned t = 0; t < SLOTS; t++) begin
                st_d[p][t]  = st_q[p][t];
                age_d[p][t] = age_q[p][t];
                if (resp_hit[p][t]) begin
                    if (st_q[p][t] == S_PEND) begin
                        ret_ev[p] = 1'b1;
                        lat_ev[p] = age_q[p][t];
                    end else begin
                        unexp_ev[p] = 1'b1;
                    end
                end
                if (st_q[p][t] == S_PEND && !resp_hit[p][t]) begin
                    if (age_q[p][t] == LAT_W'(TIMEOUT)) tmo_ev[p] = 1'b1;
                    if (iss_hit[p][t])                  dup_ev[p] = 1'b1;
                end
                if (iss_hit[p][t]) begin
                    st_d[p][t]  = S_PEND;
                    age_d[p][t] = LAT_W'(1);
                end else if (st_q[p][t] == S_PEND) begin
                    if (resp_hit[p][t] || age_q[p][t] == LAT_W'(TIMEOUT)) begin
                        st_d[p][t]  = S_IDLE;
                        age_d[p][t] = '0;
                    end else begin
                        age_d[p][t] = age_q[p][t] + LAT_W'(1);
                    end
                end
                out_d[p] = out_d[p] + OW'(st_d[p][t] == S_PEND);
            end
        end
    end

    // An event on the clearing edge survives the clear.
    always_comb begin
        dup_d   = (clr ? '0 : dup_q)   | dup_ev;
        unexp_d = (clr ? '0 : unexp_q) | unexp_ev;
        tmo_d   = (clr ? '0 : tmo_q)   | tmo_ev;
        for (int unsigned p = 0; p < NUM_PORTS; p++) begin
            if (clr) begin
                done_d[p] = CNT_W'(ret_ev[p]);
                maxl_d[p] = lat_ev[p];
            end else begin
                done_d[p] = done_q[p] + CNT_W'(ret_ev[p] && (done_q[p] != '1));
                maxl_d[p] = (lat_ev[p] > maxl_q[p]) ? lat_ev[p] : maxl_q[p];
            end
        end
    end

    always_ff @(posedge c_clk or negedge reset) begin
        if (!reset) begin
            for (int unsigned p = 0; p < NUM_PORTS; p++) begin
                for (int unsigned t = 0; t < SLOTS; t++) begin
                    st_q[p][t]  <= S_IDLE;
                    age_q[p][t] <= '0;
                end
                out_q[p]  <= '0;
                done_q[p] <= '0;
                maxl_q[p] <= '0;
            end
            dup_q   <= '0;
            unexp_q <= '0;
            tmo_q   <= '0;
        end else begin
            for (int unsigned p = 0; p < NUM_PORTS; p++) begin
                for (int unsigned t = 0; t < SLOTS; t++) begin
                    st_q[p][t]  <= st_d[p][t];
                    age_q[p][t] <= age_d[p][t];
                end
                out_q[p]  <= out_d[p];
                done_q[p] <= done_d[p];
                maxl_q[p] <= maxl_d[p];
            end
            dup_q   <= dup_d;
            unexp_q <= unexp_d;
            tmo_q   <= tmo_d;
        end
    end

    for (genvar g = 0; g < NUM_PORTS; g++) begin : g_out
        assign bus.outstanding[g*OW +: OW]    = out_q[g];
        assign bus.done_cnt[g*CNT_W +: CNT_W] = done_q[g];
        assign bus.max_lat[g*LAT_W +: LAT_W]  = maxl_q[g];
    end

    assign bus.err_dup     = dup_q;
    assign bus.err_unexp   = unexp_q;
    assign bus.err_timeout = tmo_q;
    assign bus.idle        = ~|bus.outstanding;
endmodule

// File: tb/tb_calc_resp_tracker.sv
// Bench for calc_resp_tracker: directed vector table, corner sequences and random
// traffic against a timestamp-based reference model.
module tb_calc_resp_tracker;
    localparam int NP = 4;
    localparam int TW = 2;
    localparam int TO = 64;
    localparam int CW = 16;
    localparam int LW = $clog2(TO + 1);
    localparam int S  = 1 << TW;
    localparam int OW = TW + 1;

    logic c_clk = 1'b0;
    logic reset;
    logic clr;
    int   checks = 0;
    int   errors = 0;

    always #5 c_clk = ~c_clk;

    calc_resp_tracker_if #(.NUM_PORTS(NP), .TAG_W(TW), .TIMEOUT(TO), .CNT_W(CW)) bus ();

    calc_resp_tracker #(.NUM_PORTS(NP), .TAG_W(TW), .TIMEOUT(TO), .CNT_W(CW)) dut (
        .c_clk (c_clk),
        .reset (reset),
        .clr   (clr),
        .bus   (bus)
    );

    // Reference model: pending set with issue timestamps; latency = now - issue edge.
    bit m_pend [NP][S];
    int m_iss  [NP][S];
    int m_done [NP];
    int m_max  [NP];
    bit m_dup  [NP];
    bit m_unexp[NP];
    bit m_tmo  [NP];
    int n_edge = 0;

    function automatic void m_reset();
        for (int p = 0; p < NP; p++) begin
            for (int t = 0; t < S; t++) begin
                m_pend[p][t] = 0;
                m_iss[p][t]  = 0;
            end
            m_done[p] = 0; m_max[p] = 0;
            m_dup[p] = 0; m_unexp[p] = 0; m_tmo[p] = 0;
        end
    endfunction

    function automatic void m_step(logic [NP*4-1:0] cmd, logic [NP*TW-1:0] tg,
                                   logic [NP*2-1:0] rs, logic [NP*TW-1:0] rt, bit c);
        for (int p = 0; p < NP; p++) begin
            bit pre [S];
            bit rv, cv;
            int cr, ct, lat;
            if (c) begin
                m_dup[p] = 0; m_unexp[p] = 0; m_tmo[p] = 0; m_done[p] = 0; m_max[p] = 0;
            end
            for (int t = 0; t < S; t++) pre[t] = m_pend[p][t];
            rv = (rs[p*2 +: 2] != 0);
            cv = (cmd[p*4 +: 4] != 0);
            cr = int'(rt[p*TW +: TW]);
            ct = int'(tg[p*TW +: TW]);
            if (rv) begin
                if (pre[cr]) begin
                    lat = n_edge - m_iss[p][cr];
                    m_pend[p][cr] = 0;
                    if (m_done[p] < (1 << CW) - 1) m_done[p]++;
                    if (lat > m_max[p]) m_max[p] = lat;
                end else begin
                    m_unexp[p] = 1;
                end
            end
            for (int t = 0; t < S; t++)
                if (pre[t] && !(rv && cr == t) && (n_edge - m_iss[p][t] == TO)) begin
                    m_tmo[p] = 1;
                    m_pend[p][t] = 0;
                end
            if (cv) begin
                if (pre[ct] && !(rv && cr == ct)) m_dup[p] = 1;
                m_pend[p][ct] = 1;
                m_iss[p][ct]  = n_edge;
            end
        end
    endfunction

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h at edge %0d", nm, act, exp, n_edge);
        end
    endtask

    task automatic cmp_model();
        logic [NP*OW-1:0] eo;
        logic [NP-1:0]    ed, eu, et;
        logic [NP*CW-1:0] edc;
        logic [NP*LW-1:0] eml;
        for (int p = 0; p < NP; p++) begin
            int cnt = 0;
            for (int t = 0; t < S; t++) cnt += int'(m_pend[p][t]);
            eo[p*OW +: OW]  = OW'(cnt);
            ed[p] = m_dup[p]; eu[p] = m_unexp[p]; et[p] = m_tmo[p];
            edc[p*CW +: CW] = CW'(m_done[p]);
            eml[p*LW +: LW] = LW'(m_max[p]);
        end
        chk("m_outstanding", 64'(bus.outstanding), 64'(eo));
        chk("m_idle",        64'(bus.idle),        64'(eo == '0));
        chk("m_err_dup",     64'(bus.err_dup),     64'(ed));
        chk("m_err_unexp",   64'(bus.err_unexp),   64'(eu));
        chk("m_err_timeout", 64'(bus.err_timeout), 64'(et));
        chk("m_done_cnt",    64'(bus.done_cnt),    64'(edc));
        chk("m_max_lat",     64'(bus.max_lat),     64'(eml));
    endtask

    task automatic cycle(input logic [NP*4-1:0] cmd, input logic [NP*TW-1:0] tg,
                         input logic [NP*2-1:0] rs, input logic [NP*TW-1:0] rt, input bit c);
        bus.req_cmd_in = cmd;
        bus.req_tag_in = tg;
        bus.out_resp   = rs;
        bus.out_tag    = rt;
        clr            = c;
        @(posedge c_clk);
        n_edge++;
        m_step(cmd, tg, rs, rt, c);
        #1;
        cmp_model();
    endtask

    task automatic idle_cycles(input int n);
        for (int i = 0; i < n; i++) cycle('0, '0, '0, '0, 1'b0);
    endtask

    task automatic rand_phase(input int n, input int iss_den, input int rsp_den);
        for (int i = 0; i < n; i++) begin
            logic [NP*4-1:0]  c;
            logic [NP*TW-1:0] tg, rt;
            logic [NP*2-1:0]  rs;
            c = '0; tg = '0; rs = '0; rt = '0;
            for (int p = 0; p < NP; p++) begin
                if ($urandom_range(0, iss_den - 1) == 0) c[p*4 +: 4] = 4'($urandom_range(1, 15));
                tg[p*TW +: TW] = TW'($urandom_range(0, S - 1));
                if ($urandom_range(0, rsp_den - 1) == 0) rs[p*2 +: 2] = 2'($urandom_range(1, 3));
                rt[p*TW +: TW] = TW'($urandom_range(0, S - 1));
            end
            cycle(c, tg, rs, rt, $urandom_range(0, 49) == 0);
        end
    endtask

    typedef struct {
        logic [15:0] cmd;
        logic [7:0]  tg;
        logic [7:0]  rs;
        logic [7:0]  rt;
        bit          c;
        logic [11:0] o;
        bit          id;
        logic [3:0]  d, u, t;
        logic [63:0] dc;
        logic [27:0] ml;
    } vec_t;

    vec_t tbl [15];

    initial begin
        #2_000_000;
        $display("FAIL watchdog expired at edge %0d", n_edge);
        $fatal(1);
    end

    initial begin
        tbl[0]  = '{16'h0001, 8'h02, 8'h00, 8'h00, 1'b0, 12'h001, 1'b0, 4'h0, 4'h0, 4'h0, 64'h0, 28'h0};
        for (int i = 1; i <= 4; i++)
            tbl[i] = '{16'h0000, 8'h00, 8'h00, 8'h00, 1'b0, 12'h001, 1'b0, 4'h0, 4'h0, 4'h0, 64'h0, 28'h0};
        tbl[5]  = '{16'h0000, 8'h00, 8'h01, 8'h02, 1'b0, 12'h000, 1'b1, 4'h0, 4'h0, 4'h0, 64'h1, 28'h5};
        tbl[6]  = '{16'h0010, 8'h04, 8'h80, 8'h00, 1'b0, 12'h008, 1'b0, 4'h0, 4'h8, 4'h0, 64'h1, 28'h5};
        tbl[7]  = '{16'h0000, 8'h00, 8'h00, 8'h00, 1'b0, 12'h008, 1'b0, 4'h0, 4'h8, 4'h0, 64'h1, 28'h5};
        tbl[8]  = '{16'h0010, 8'h04, 8'h00, 8'h00, 1'b0, 12'h008, 1'b0, 4'h2, 4'h8, 4'h0, 64'h1, 28'h5};
        tbl[9]  = '{16'h0000, 8'h00, 8'h00, 8'h00, 1'b0, 12'h008, 1'b0, 4'h2, 4'h8, 4'h0, 64'h1, 28'h5};
        tbl[10] = tbl[9];
        tbl[11] = '{16'h0000, 8'h00, 8'h0C, 8'h04, 1'b0, 12'h000, 1'b1, 4'h2, 4'h8, 4'h0, 64'h1_0001, 28'h185};
        tbl[12] = '{16'h0100, 8'h00, 8'h00, 8'h00, 1'b1, 12'h040, 1'b0, 4'h0, 4'h0, 4'h0, 64'h0, 28'h0};
        tbl[13] = '{16'h0100, 8'h00, 8'h10, 8'h00, 1'b0, 12'h040, 1'b0, 4'h0, 4'h0, 4'h0, 64'h1_0000_0000, 28'h4000};
        tbl[14] = '{16'h0000, 8'h00, 8'h10, 8'h00, 1'b1, 12'h000, 1'b1, 4'h0, 4'h0, 4'h0, 64'h1_0000_0000, 28'h4000};

        bus.req_cmd_in = '0; bus.req_tag_in = '0; bus.out_resp = '0; bus.out_tag = '0;
        clr = 1'b0;
        reset = 1'b1;
        #1 reset = 1'b0;
        m_reset();
        repeat (2) @(posedge c_clk);
        #1;
        chk("rst_outstanding", 64'(bus.outstanding), 64'h0);
        chk("rst_idle",        64'(bus.idle),        64'h1);
        chk("rst_errs",        64'({bus.err_dup, bus.err_unexp, bus.err_timeout}), 64'h0);
        chk("rst_done",        64'(bus.done_cnt),    64'h0);
        chk("rst_maxlat",      64'(bus.max_lat),     64'h0);
        reset = 1'b1;

        for (int i = 0; i < 15; i++) begin
            cycle(tbl[i].cmd, tbl[i].tg, tbl[i].rs, tbl[i].rt, tbl[i].c);
            chk($sformatf("v%0d_outstanding", i), 64'(bus.outstanding), 64'(tbl[i].o));
            chk($sformatf("v%0d_idle", i),        64'(bus.idle),        64'(tbl[i].id));
            chk($sformatf("v%0d_err_dup", i),     64'(bus.err_dup),     64'(tbl[i].d));
            chk($sformatf("v%0d_err_unexp", i),   64'(bus.err_unexp),   64'(tbl[i].u));
            chk($sformatf("v%0d_err_timeout", i), 64'(bus.err_timeout), 64'(tbl[i].t));
            chk($sformatf("v%0d_done_cnt", i),    64'(bus.done_cnt),    tbl[i].dc);
            chk($sformatf("v%0d_max_lat", i),     64'(bus.max_lat),     64'(tbl[i].ml));
        end

        // Port index 2: four tags out, returned out of order 3,1,0,2.
        cycle('0, '0, '0, '0, 1'b1);
        for (int t = 0; t < 4; t++) cycle(16'h0100, 8'(t << 4), '0, '0, 1'b0);
        chk("p2_peak", 64'(bus.outstanding[8:6]), 64'd4);
        cycle('0, '0, 8'h10, 8'h30, 1'b0);
        cycle('0, '0, 8'h10, 8'h10, 1'b0);
        cycle('0, '0, 8'h10, 8'h00, 1'b0);
        cycle('0, '0, 8'h10, 8'h20, 1'b0);
        chk("p2_done", 64'(bus.done_cnt[47:32]), 64'd4);
        chk("p2_maxlat", 64'(bus.max_lat[20:14]), 64'd6);
        chk("p2_errs", 64'({bus.err_dup, bus.err_unexp, bus.err_timeout}), 64'h0);

        // Port index 0, tag 3: latency TIMEOUT accepted, then a real timeout.
        cycle('0, '0, '0, '0, 1'b1);
        cycle(16'h0001, 8'h03, '0, '0, 1'b0);
        idle_cycles(TO - 1);
        cycle('0, '0, 8'h01, 8'h03, 1'b0);
        chk("to_lat64", 64'(bus.max_lat[6:0]), 64'd64);
        chk("to_noerr", 64'(bus.err_timeout[0]), 64'd0);
        cycle(16'h0001, 8'h03, '0, '0, 1'b0);
        idle_cycles(TO - 1);
        chk("to_before", 64'({bus.err_timeout[0], bus.outstanding[2:0]}), 64'h1);
        idle_cycles(1);
        chk("to_flag", 64'(bus.err_timeout[0]), 64'd1);
        chk("to_out0", 64'(bus.outstanding[2:0]), 64'd0);
        idle_cycles(5);
        chk("to_unexp_pre", 64'(bus.err_unexp[0]), 64'd0);
        cycle('0, '0, 8'h01, 8'h03, 1'b0);
        chk("to_unexp", 64'(bus.err_unexp[0]), 64'd1);

        // Mid-operation reset with two tags pending on port index 1.
        cycle('0, '0, '0, '0, 1'b1);
        cycle(16'h0010, 8'h00, '0, '0, 1'b0);
        cycle(16'h0010, 8'h04, '0, '0, 1'b0);
        #2 reset = 1'b0;
        m_reset();
        #1;
        chk("mr_outstanding", 64'(bus.outstanding), 64'h0);
        chk("mr_idle",        64'(bus.idle),        64'h1);
        chk("mr_outputs",     64'({bus.err_dup, bus.err_unexp, bus.err_timeout}) |
                              64'(bus.done_cnt) | 64'(bus.max_lat), 64'h0);
        @(posedge c_clk);
        #1 reset = 1'b1;
        cycle('0, '0, 8'h04, 8'h00, 1'b0);
        chk("mr_unexp", 64'(bus.err_unexp[1]), 64'd1);
        cycle(16'h0010, 8'h0C, '0, '0, 1'b0);
        cycle('0, '0, 8'h04, 8'h0C, 1'b0);
        cycle(16'h0010, 8'h08, '0, '0, 1'b0);
        chk("clr_pre_done", 64'(bus.done_cnt[31:16]), 64'd1);
        cycle('0, '0, 8'h08, 8'h08, 1'b1);
        chk("clr_retire_done", 64'(bus.done_cnt[31:16]), 64'd1);
        chk("clr_retire_maxlat", 64'(bus.max_lat[13:7]), 64'd1);

        rand_phase(800, 4, 3);
        rand_phase(500, 30, 40);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/calc_resp_tracker.md
Name: calc_resp_tracker

Overview:
- Synthesizable, parametrised transaction tracker for the calc request/response ports.
- Sits beside calc2_top and snoops every port's request (cmd/tag) and response (resp/tag) lanes.
- Tracks outstanding tags and measures per-tag latency.
- Flags duplicate issues, unexpected responses and timeouts.
- Keeps completion counts and worst-case latency; the port count is generalised beyond the fixed four.

Parameters:
NUM_PORTS, 4, number of request/response port pairs tracked
TAG_W, 2, tag width; each port has 2**TAG_W tag slots
TIMEOUT, 64, max legal latency in c_clk cycles (>=2)
CNT_W, 16, completion counter width
(derived) LAT_W = clog2(TIMEOUT+1)

Ports:
c_clk  in  1  sole clock, all state on rising edge
reset  in  1  asynchronous, active-low reset
clr  in  1  sync clear of sticky flags, done_cnt, max_lat
req_cmd_in  in  NUM_PORTS*4  per-port command; 0 = no request
req_tag_in  in  NUM_PORTS*TAG_W  per-port request tag
out_resp  in  NUM_PORTS*2  per-port response; 0 = none, 1..3 = completion
out_tag  in  NUM_PORTS*TAG_W  per-port response tag
outstanding  out  NUM_PORTS*(TAG_W+1)  pending-tag count per port
err_dup  out  NUM_PORTS  sticky: issue to an already-pending tag
err_unexp  out  NUM_PORTS  sticky: response to a non-pending tag
err_timeout  out  NUM_PORTS  sticky: tag exceeded TIMEOUT
done_cnt  out  NUM_PORTS*CNT_W  saturating completed-response count
max_lat  out  NUM_PORTS*LAT_W  largest observed latency
idle  out  1  high when every outstanding count is 0

Behaviour:
- Reset (reset=0, async): all slots IDLE, ages 0, all outputs 0 except idle=1. Tracking resumes on the first edge after deassertion.
- Per slot (port p, tag t), FSM IDLE/PENDING with age register (LAT_W bits).
- Each edge evaluates retire first, then issue, both against the pre-edge slot state.
- Retire: resp!=0 and slot PENDING gives latency = age.
  - Slot -> IDLE; done_cnt++ (saturates at all-ones).
  - max_lat = max(max_lat, age).
- Unexpected: resp!=0 and slot IDLE before the edge sets err_unexp[p]. This includes a tag issued on the same edge; slot state is unaffected.
- Issue: cmd!=0 on slot t sets slot -> PENDING, age := 1.
  - If the slot was PENDING and not retired this edge, also set err_dup[p] (age re-arms to 1).
- Same-edge retire and issue of the same tag: legal back-to-back. Retire counts, slot re-armed, no error.
- Aging: PENDING with no retire/issue this edge increments age.
- Timeout: PENDING with age==TIMEOUT and no response this edge sets err_timeout[p]. Slot -> IDLE, no done_cnt increment; a later response is unexpected.
  - Latency TIMEOUT is legal; latency TIMEOUT+1 is not.
- outstanding[p] is registered and equals the popcount of PENDING slots after the edge, range 0..2**TAG_W.
- idle is combinational from the outstanding registers.
- clr: synchronous, clears err_*, done_cnt, max_lat only; pending slots and ages are untouched.
  - An error or retire on the same edge as clr wins: flag set, done_cnt=1, max_lat=that latency.
- Ports are fully independent; there is no cross-port tag matching.

Test Plan:
- Reset, then port1 cmd=1 tag=2 at edge e0, resp=1 tag=2 at e0+5 -> outstanding[0] 1 from e0 to e0+4 then 0; done_cnt[0]=1; max_lat[0]=5; no errors; idle=1 after.
- Port3 issues tags 0,1,2,3 on consecutive edges; responses return in order 3,1,0,2 -> outstanding[2] peaks at 4; done_cnt[2]=4; max_lat correct per tag; no errors.
- Port2 tag=1 issued, reissued 2 edges later without response -> err_dup[1]=1; outstanding stays 1; response 3 edges after reissue gives max_lat=3.
- Port4 resp=2 tag=0 with nothing pending -> err_unexp[3]=1. Same-edge response+issue of pending tag 1 -> no error, done_cnt +1, outstanding unchanged.
- TIMEOUT=64, port1 tag=3 issued:
  - Response at latency 64 -> accepted, max_lat=64.
  - Second issue with no response -> err_timeout[0] at age 64 edge+1; outstanding->0; response at latency 70 -> err_unexp[0]=1.
- Mid-operation reset with two tags pending on port2 -> all outputs 0, idle=1 immediately. A post-reset response to those tags -> err_unexp[1]=1. clr asserted together with a retire -> done_cnt=1.
